// File: rtl/cpu_stage_sequencer_pkg.sv
// Shared types for the multi-cycle stage sequencer.
// One-hot state encoding, trap causes and PC step.
package cpu_pkg;

    localparam int ST_IDLE      = 0;
    localparam int ST_FETCH     = 1;
    localparam int ST_DECODE    = 2;
    localparam int ST_EXECUTE   = 3;
    localparam int ST_MEMORY    = 4;
    localparam int ST_WRITEBACK = 5;
    localparam int ST_TRAP      = 6;

    typedef enum logic [6:0] {
        IDLE      = 7'b000_0001,
        FETCH     = 7'b000_0010,
        DECODE    = 7'b000_0100,
        EXECUTE   = 7'b000_1000,
        MEMORY    = 7'b001_0000,
        WRITEBACK = 7'b010_0000,
        TRAP      = 7'b100_0000
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_FETCH   = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } cause_e;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/cpu_stage_sequencer_if.sv
// Request/ready bundle between the sequencer and the stage units.
// master = sequencer side, slave = stage-unit side.
interface cpu_stage_sequencer_if;

    logic        o_fetch;
    logic        i_fetch_ready;
    logic        i_fetch_fault;
    logic        o_decode;
    logic        i_decode_ready;
    logic        i_decode_illegal;
    logic        o_execute;
    logic        i_execute_ready;
    logic        i_execute_branch;
    logic [31:0] i_execute_pc_next;
    logic        i_execute_mem;
    logic        o_memory;
    logic        i_memory_ready;
    logic        o_writeback;

    modport master (
        output o_fetch, o_decode, o_execute,
        output o_memory, o_writeback,
        input  i_fetch_ready, i_fetch_fault,
        input  i_decode_ready, i_decode_illegal,
        input  i_execute_ready, i_execute_branch,
        input  i_execute_pc_next, i_execute_mem,
        input  i_memory_ready
    );

    modport slave (
        input  o_fetch, o_decode, o_execute,
        input  o_memory, o_writeback,
        output i_fetch_ready, i_fetch_fault,
        output i_decode_ready, i_decode_illegal,
        output i_execute_ready, i_execute_branch,
        output i_execute_pc_next, i_execute_mem,
        output i_memory_ready
    );

endinterface

// File: rtl/cpu_stage_sequencer_watchdog.sv
// Stage watchdog: counts cycles a request waits for its ready.
// TIMEOUT of 0 disables expiry.
module cpu_stage_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST =
        W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit ARMED = (TIMEOUT > 0);

    logic [W-1:0] count;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable && count != LAST)
            count <= count + W'(1);
    end

    // Fires on the TIMEOUT-th edge after entry; ready on that edge wins upstream.
    assign expire = ARMED && enable && (count == LAST);

endmodule

// File: rtl/cpu_stage_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode, execute, memory, writeback.
// Owns PC update, retire count and trap entry.
module cpu_stage_sequencer
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
    parameter int          TIMEOUT     = 1024
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_run,
    cpu_stage_sequencer_if.master stg,
    output logic [31:0]           o_pc,
    output logic [31:0]           o_retired,
    output logic                  o_trap,
    output logic [1:0]            o_trap_cause,
    output logic                  o_halted
);

    state_e      state_q, state_d;
    cause_e      cause_q, cause_d;
    logic [31:0] pc_q, retired_q, target_q;
    logic        branch_q, run_low_q;
    logic        wd_clear, wd_enable, wd_expire;

    assign wd_clear  = (state_d != state_q);
    assign wd_enable = stg.o_fetch | stg.o_decode
                     | stg.o_execute | stg.o_memory;

    cpu_stage_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expire  (wd_expire)
    );

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        unique case (1'b1)
            state_q[ST_IDLE]: begin
                if (i_run) state_d = FETCH;
            end
            state_q[ST_FETCH]: begin
                if (stg.i_fetch_ready) begin
                    if (stg.i_fetch_fault) begin
                        state_d = TRAP;
                        cause_d = CAUSE_FETCH;
                    end else begin
                        state_d = DECODE;
                    end
                end
            end
            state_q[ST_DECODE]: begin
                if (stg.i_decode_ready) begin
                    if (stg.i_decode_illegal) begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end else begin
                        state_d = EXECUTE;
                    end
                end
            end
            state_q[ST_EXECUTE]: begin
                if (stg.i_execute_ready)
                    state_d = stg.i_execute_mem ? MEMORY : WRITEBACK;
            end
            state_q[ST_MEMORY]: begin
                if (stg.i_memory_ready) state_d = WRITEBACK;
            end
            state_q[ST_WRITEBACK]: begin
                state_d = i_run ? FETCH : IDLE;
            end
            state_q[ST_TRAP]: begin
                if (run_low_q && i_run) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase
        // Expiry only applies while still waiting, so a ready on the same edge wins.
        if (wd_expire && state_d == state_q) begin
            state_d = TRAP;
            cause_d = CAUSE_TIMEOUT;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q         <= IDLE;
            cause_q         <= CAUSE_FETCH;
            pc_q            <= RESET_PC;
            retired_q       <= '0;
            target_q        <= '0;
            branch_q        <= 1'b0;
            run_low_q       <= 1'b0;
            stg.o_fetch     <= 1'b0;
            stg.o_decode    <= 1'b0;
            stg.o_execute   <= 1'b0;
            stg.o_memory    <= 1'b0;
            stg.o_writeback <= 1'b0;
            o_trap          <= 1'b0;
            o_halted        <= 1'b1;
        end else begin
            state_q         <= state_d;
            cause_q         <= cause_d;
            stg.o_fetch     <= state_d[ST_FETCH];
            stg.o_decode    <= state_d[ST_DECODE];
            stg.o_execute   <= state_d[ST_EXECUTE];
            stg.o_memory    <= state_d[ST_MEMORY];
            stg.o_writeback <= state_d[ST_WRITEBACK];
            o_trap          <= state_d[ST_TRAP];
            o_halted        <= state_d[ST_IDLE];
            // A low i_run seen while trapped arms the exit on its next high.
            run_low_q <= state_q[ST_TRAP] && state_d[ST_TRAP]
                       && (run_low_q || !i_run);
            if (state_q[ST_EXECUTE] && stg.i_execute_ready) begin
                branch_q <= stg.i_execute_branch;
                target_q <= stg.i_execute_pc_next;
            end
            if (state_q[ST_WRITEBACK]) begin
                pc_q      <= branch_q ? target_q : pc_q + PC_STEP;
                retired_q <= retired_q + 32'd1;
            end else if (state_q[ST_TRAP] && state_d[ST_FETCH]) begin
                pc_q <= TRAP_VECTOR;
            end
        end
    end

    assign o_pc         = pc_q;
    assign o_retired    = retired_q;
    assign o_trap_cause = cause_q;

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Randomised bench for cpu_stage_sequencer against an
// instruction-level model of PC, retire count and latency.
module tb_cpu_stage_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] TV     = 32'h0000_0100;
    localparam int          TMO    = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        run   = 1'b0;
    logic [31:0] pc, retired;
    logic        trap, halted;
    logic [1:0]  cause;

    int          n_cmp = 0;
    int          n_bad = 0;
    longint      cyc   = 0;
    bit          noise = 1'b0;
    logic [31:0] pc_m  = RST_PC;
    logic [31:0] ret_m = '0;

    cpu_stage_sequencer_if stg ();

    cpu_stage_sequencer #(
        .RESET_PC    (RST_PC),
        .TRAP_VECTOR (TV),
        .TIMEOUT     (TMO)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_run        (run),
        .stg          (stg),
        .o_pc         (pc),
        .o_retired    (retired),
        .o_trap       (trap),
        .o_trap_cause (cause),
        .o_halted     (halted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic logic req(input int s);
        case (s)
            0:       return stg.o_fetch;
            1:       return stg.o_decode;
            2:       return stg.o_execute;
            default: return stg.o_memory;
        endcase
    endfunction

    task automatic set_ready(input int s, input logic v);
        case (s)
            0:       stg.i_fetch_ready   = v;
            1:       stg.i_decode_ready  = v;
            2:       stg.i_execute_ready = v;
            default: stg.i_memory_ready  = v;
        endcase
    endtask

    task automatic quiet();
        for (int s = 0; s < 4; s++) set_ready(s, 1'b0);
        stg.i_fetch_fault     = 1'b0;
        stg.i_decode_illegal  = 1'b0;
        stg.i_execute_branch  = 1'b0;
        stg.i_execute_mem     = 1'b0;
        stg.i_execute_pc_next = '0;
    endtask

    // Garbage on readies of idle stages and on all qualifiers.
    task automatic drive_noise();
        for (int s = 0; s < 4; s++)
            set_ready(s, (noise && !req(s)) ?
                      1'($urandom_range(0, 1)) : 1'b0);
        stg.i_fetch_fault     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        stg.i_decode_illegal  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        stg.i_execute_branch  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        stg.i_execute_mem     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        stg.i_execute_pc_next = noise ? $urandom : 32'h0;
    endtask

    task automatic do_stage(input int s, input int delay, input bit q,
                            input logic [31:0] pcn, input bit q2,
                            output bit ok, output longint t_seen);
        ok = 1'b0;
        t_seen = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (req(s)) ok = 1'b1;
            else begin
                drive_noise();
                @(negedge clk);
            end
        end
        if (!ok) return;
        t_seen = cyc;
        repeat (delay) begin
            drive_noise();
            @(negedge clk);
        end
        drive_noise();
        set_ready(s, 1'b1);
        case (s)
            0: stg.i_fetch_fault = q;
            1: stg.i_decode_illegal = q;
            2: begin
                stg.i_execute_branch  = q;
                stg.i_execute_pc_next = pcn;
                stg.i_execute_mem     = q2;
            end
            default: ;
        endcase
        @(negedge clk);
        quiet();
    endtask

    task automatic run_instr(input bit br, input logic [31:0] tgt,
                             input bit mem, input int dmax,
                             input bit stop, output bit ok,
                             output logic [31:0] pc_seen,
                             output bit mem_seen, output int dsum,
                             output longint t0);
        int d;
        longint t;
        pc_seen = '0;
        mem_seen = 1'b0;
        dsum = 0;
        d = $urandom_range(0, dmax);
        dsum += d;
        do_stage(0, d, 1'b0, '0, 1'b0, ok, t0);
        if (!ok) return;
        pc_seen = pc;
        if (stop) run = 1'b0;
        d = $urandom_range(0, dmax);
        dsum += d;
        do_stage(1, d, 1'b0, '0, 1'b0, ok, t);
        if (!ok) return;
        d = $urandom_range(0, dmax);
        dsum += d;
        do_stage(2, d, br, tgt, mem, ok, t);
        if (!ok) return;
        mem_seen = stg.o_memory;
        if (mem_seen) begin
            d = $urandom_range(0, dmax);
            dsum += d;
            do_stage(3, d, 1'b0, '0, 1'b0, ok, t);
            if (!ok) return;
        end
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++)
            if (stg.o_writeback) ok = 1'b1;
            else @(negedge clk);
        if (!ok) return;
        @(negedge clk);
    endtask

    function automatic logic [6:0] outs();
        return {stg.o_fetch, stg.o_decode, stg.o_execute,
                stg.o_memory, stg.o_writeback, trap, halted};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b0;
        quiet();
        repeat (2) @(negedge clk);
        n_cmp++;
        if (outs() !== 7'b0000001) begin
            n_bad++;
            $display("FAIL reset_outs: got %b want 0000001", outs());
        end
        n_cmp++;
        if ({pc, retired, cause} !== {RST_PC, 32'd0, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_regs: pc %h ret %0d cause %0d",
                     pc, retired, cause);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (outs() !== 7'b0000001) begin
            n_bad++;
            $display("FAIL idle_hold: got %b want 0000001", outs());
        end
    endtask

    task automatic test_straight_line();
        bit ok, ms;
        logic [31:0] ps;
        int ds;
        longint t0, tf;
        run = 1'b1;
        tf = 0;
        for (int k = 0; k < 3; k++) begin
            run_instr(1'b0, '0, 1'b0, 0, 1'b0, ok, ps, ms, ds, t0);
            if (k == 0) tf = t0;
            n_cmp++;
            if (!ok || ps !== pc_m) begin
                n_bad++;
                $display("FAIL straight_pc%0d: ok %0d pc %h want %h",
                         k, ok, ps, pc_m);
            end
            pc_m = pc_m + 32'd4;
            ret_m = ret_m + 32'd1;
        end
        n_cmp++;
        if (pc !== 32'd12 || retired !== 32'd3) begin
            n_bad++;
            $display("FAIL straight_end: pc %h ret %0d want 12/3",
                     pc, retired);
        end
        n_cmp++;
        if (cyc - tf !== 64'd12) begin
            n_bad++;
            $display("FAIL straight_cycles: got %0d want 12", cyc - tf);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        longint t;
        do_stage(0, 0, 1'b0, '0, 1'b0, ok, t);
        do_stage(1, 0, 1'b0, '0, 1'b0, ok, t);
        n_cmp++;
        if (stg.o_execute !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre: o_execute %b want 1", stg.o_execute);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (outs() !== 7'b0000001) begin
            n_bad++;
            $display("FAIL mid_outs: got %b want 0000001", outs());
        end
        n_cmp++;
        if ({pc, retired, cause} !== {RST_PC, 32'd0, 2'd0}) begin
            n_bad++;
            $display("FAIL mid_regs: pc %h ret %0d cause %0d",
                     pc, retired, cause);
        end
        pc_m = RST_PC;
        ret_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_branch_mem();
        bit ok, ms;
        logic [31:0] ps;
        int ds;
        longint t0;
        run_instr(1'b1, 32'h40, 1'b1, 0, 1'b0, ok, ps, ms, ds, t0);
        n_cmp++;
        if (!ok || ms !== 1'b1 || cyc - t0 !== 64'd5) begin
            n_bad++;
            $display("FAIL load_mem: ok %0d mem %0d cyc %0d want 1/1/5",
                     ok, ms, cyc - t0);
        end
        ret_m = ret_m + 32'd1;
        pc_m = 32'h40;
        run_instr(1'b0, '0, 1'b0, 0, 1'b0, ok, ps, ms, ds, t0);
        n_cmp++;
        if (!ok || ps !== 32'h40 || ms !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_target: pc %h mem %0d want 40/0",
                     ps, ms);
        end
        pc_m = 32'h44;
        ret_m = ret_m + 32'd1;
    endtask

    task automatic test_random();
        bit ok, ms, br, mem;
        logic [31:0] ps, tgt;
        int ds;
        longint t0;
        noise = 1'b1;
        for (int k = 0; k < 24; k++) begin
            br  = 1'($urandom_range(0, 1));
            mem = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFFC;
                1:       tgt = $urandom;
                default: tgt = $urandom & 32'h0000_FFFC;
            endcase
            run_instr(br, tgt, mem, 3, 1'b0, ok, ps, ms, ds, t0);
            n_cmp++;
            if (!ok) begin
                n_bad++;
                $display("FAIL rnd_handshake%0d: stage never requested", k);
                break;
            end
            n_cmp++;
            if (ps !== pc_m || ms !== mem) begin
                n_bad++;
                $display("FAIL rnd_fetch%0d: pc %h mem %0d want %h %0d",
                         k, ps, ms, pc_m, mem);
            end
            n_cmp++;
            if (cyc - t0 !== longint'(4 + int'(mem) + ds)) begin
                n_bad++;
                $display("FAIL rnd_cycles%0d: got %0d want %0d",
                         k, cyc - t0, 4 + int'(mem) + ds);
            end
            pc_m = br ? tgt : pc_m + 32'd4;
            ret_m = ret_m + 32'd1;
            n_cmp++;
            if (pc !== pc_m || retired !== ret_m) begin
                n_bad++;
                $display("FAIL rnd_state%0d: pc %h ret %0d want %h %0d",
                         k, pc, retired, pc_m, ret_m);
            end
        end
        noise = 1'b0;
    endtask

    task automatic leave_trap();
        run = 1'b0;
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_trap();
        bit ok, wb;
        longint t;
        do_stage(0, 0, 1'b0, '0, 1'b0, ok, t);
        do_stage(1, 0, 1'b1, '0, 1'b0, ok, t);
        n_cmp++;
        if (!ok || trap !== 1'b1 || cause !== 2'd1) begin
            n_bad++;
            $display("FAIL illegal_trap: trap %b cause %0d want 1/1",
                     trap, cause);
        end
        wb = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (stg.o_writeback) wb = 1'b1;
        end
        n_cmp++;
        if (trap !== 1'b1 || wb !== 1'b0 || retired !== ret_m) begin
            n_bad++;
            $display("FAIL illegal_hold: trap %b wb %b ret %0d want 1/0/%0d",
                     trap, wb, retired, ret_m);
        end
        leave_trap();
        n_cmp++;
        if (stg.o_fetch !== 1'b1 || trap !== 1'b0 || pc !== TV) begin
            n_bad++;
            $display("FAIL trap_exit: fetch %b trap %b pc %h want 1/0/%h",
                     stg.o_fetch, trap, pc, TV);
        end
        do_stage(0, 1, 1'b1, '0, 1'b0, ok, t);
        n_cmp++;
        if (!ok || trap !== 1'b1 || cause !== 2'd0 || pc !== TV) begin
            n_bad++;
            $display("FAIL fault_trap: trap %b cause %0d pc %h", trap,
                     cause, pc);
        end
        leave_trap();
        pc_m = TV;
    endtask

    task automatic test_timeout();
        bit ok;
        longint t;
        do_stage(0, 0, 1'b0, '0, 1'b0, ok, t);
        do_stage(1, 0, 1'b0, '0, 1'b0, ok, t);
        do_stage(2, 0, 1'b0, '0, 1'b1, ok, t);
        repeat (TMO - 1) @(negedge clk);
        n_cmp++;
        if (!ok || stg.o_memory !== 1'b1 || trap !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_wait: mem %b trap %b want 1/0",
                     stg.o_memory, trap);
        end
        @(negedge clk);
        n_cmp++;
        if (trap !== 1'b1 || cause !== 2'd2 || stg.o_memory !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_expire: trap %b cause %0d mem %b",
                     trap, cause, stg.o_memory);
        end
        leave_trap();
        n_cmp++;
        if (cause !== 2'd2 || pc !== TV || retired !== ret_m) begin
            n_bad++;
            $display("FAIL wd_after: cause %0d pc %h ret %0d", cause,
                     pc, retired);
        end
        do_stage(0, 0, 1'b0, '0, 1'b0, ok, t);
        do_stage(1, 0, 1'b0, '0, 1'b0, ok, t);
        do_stage(2, 0, 1'b0, '0, 1'b1, ok, t);
        repeat (TMO - 1) @(negedge clk);
        stg.i_memory_ready = 1'b1;
        @(negedge clk);
        stg.i_memory_ready = 1'b0;
        n_cmp++;
        if (stg.o_writeback !== 1'b1 || trap !== 1'b0) begin
            n_bad++;
            $display("FAIL wd_race: wb %b trap %b want 1/0",
                     stg.o_writeback, trap);
        end
        @(negedge clk);
        pc_m = TV + 32'd4;
        ret_m = ret_m + 32'd1;
        n_cmp++;
        if (pc !== pc_m || retired !== ret_m) begin
            n_bad++;
            $display("FAIL wd_retire: pc %h ret %0d want %h %0d",
                     pc, retired, pc_m, ret_m);
        end
    endtask

    task automatic test_halt_wrap();
        bit ok, ms;
        logic [31:0] ps;
        int ds;
        longint t0;
        run_instr(1'b0, '0, 1'b0, 1, 1'b1, ok, ps, ms, ds, t0);
        pc_m = pc_m + 32'd4;
        ret_m = ret_m + 32'd1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (!ok || outs() !== 7'b0000001 || retired !== ret_m
            || pc !== pc_m) begin
            n_bad++;
            $display("FAIL halt: ok %0d outs %b ret %0d pc %h", ok,
                     outs(), retired, pc);
        end
        force dut.retired_q = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        #1;
        n_cmp++;
        if (retired !== 32'hFFFF_FFFF) begin
            n_bad++;
            $display("FAIL wrap_preload: got %h want ffffffff", retired);
        end
        @(negedge clk);
        run = 1'b1;
        run_instr(1'b0, '0, 1'b0, 1, 1'b0, ok, ps, ms, ds, t0);
        n_cmp++;
        if (!ok || retired !== 32'd0 || ps !== pc_m) begin
            n_bad++;
            $display("FAIL wrap: ok %0d ret %h pc %h want 0 %h", ok,
                     retired, ps, pc_m);
        end
    endtask

    initial begin
        quiet();
        @(negedge clk);
        test_reset();
        test_straight_line();
        test_reset_mid();
        test_branch_mem();
        test_random();
        test_trap();
        test_timeout();
        test_halt_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
